// File: rtl/nios2_c_pio_pkg.sv
// nios2_c_pio_pkg: shared register map, edge-select encodings and sizing helper for the PIO edge block
package nios2_c_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_EDGESEL = 3'd4;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_ANY  = 2'd3
    } edge_sel_e;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nios2_c_pio_debounce.sv
// nios2_c_pio_debounce: one-bit input synchronizer followed by a stable-count debounce filter
module nios2_c_pio_debounce
    import nios2_c_pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic filt
);

    logic [SYNC_STAGES-1:0] sync;

    // shift the asynchronous input through the synchronizer chain
    always_ff @(posedge clk) begin
        sync <= reset ? '0 : {sync[SYNC_STAGES-2:0], din};
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign filt = sync[SYNC_STAGES-1];
        end else begin : g_filter
            localparam int CW = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] cnt;
            logic          level;
            // accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt   <= '0;
                    level <= 1'b0;
                end else if (sync[SYNC_STAGES-1] == level) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    cnt   <= '0;
                    level <= sync[SYNC_STAGES-1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            assign filt = level;
        end
    endgenerate

endmodule

// File: rtl/nios2_c_pio_edge.sv
// nios2_c_pio_edge: Avalon-style PIO input port with debounce, edge capture and level/edge interrupt
module nios2_c_pio_edge
    import nios2_c_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] set_bits;
    logic [WIDTH-1:0] clr_bits;
    edge_sel_e        edgesel;
    logic             wr;
    logic [31:0]      rd_next;
    logic             irq_next;
    logic             unused_wdata;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            nios2_c_pio_debounce #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk  (clk),
                .reset(reset),
                .din  (in_port[i]),
                .filt (filt[i])
            );
        end
    endgenerate

    assign wr           = chipselect & ~write_n;
    assign rise         = filt & ~prev;
    assign fall         = ~filt & prev;
    assign unused_wdata = ^writedata;

    // edge selection, write-one-to-clear mask, read mux and next interrupt level
    always_comb begin
        set_bits = ((edgesel == EDGE_RISE || edgesel == EDGE_ANY) ? rise : '0)
                 | ((edgesel == EDGE_FALL || edgesel == EDGE_ANY) ? fall : '0);
        clr_bits = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
        rd_next  = (address == ADDR_DATA)    ? 32'(filt)        :
                   (address == ADDR_IRQMASK) ? 32'(irqmask)     :
                   (address == ADDR_EDGECAP) ? 32'(edgecapture) :
                   (address == ADDR_EDGESEL) ? 32'(edgesel)     : 32'd0;
        irq_next = (edgesel == EDGE_NONE) ? |(filt & irqmask) : |(edgecapture & irqmask);
    end

    // register state; a capture in the same cycle as its clear survives
    always_ff @(posedge clk) begin
        if (reset) begin
            prev        <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            edgesel     <= EDGE_NONE;
            readdata    <= '0;
            irq         <= 1'b0;
        end else begin
            prev        <= filt;
            edgecapture <= (edgecapture & ~clr_bits) | set_bits;
            if (wr && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
            if (wr && address == ADDR_EDGESEL) edgesel <= edge_sel_e'(writedata[1:0]);
            readdata    <= rd_next;
            irq         <= irq_next;
        end
    end

endmodule

// File: doc/nios2_c_pio_edge.md
NIOS2_C_PIO_EDGE -- requirements
Module: nios2_c_pio_edge

Interface
REQ-001 Parameter WIDTH, default 4: input port width, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops per bit, legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 0: stable cycles required before a level change is accepted; 0 bypasses debounce; legal range 0..65535.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 address  in  3  register word address.
REQ-007 chipselect  in  1  slave select.
REQ-008 write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-009 writedata  in  32  write data.
REQ-010 in_port  in  WIDTH  asynchronous external inputs.
REQ-011 readdata  out  32  registered read data.
REQ-012 irq  out  1  registered, level-sensitive interrupt request.

Function
REQ-013 Register map: 0 data (RO), 2 irqmask (RW), 3 edgecapture (RW1C), 4 edgesel (RW, 2 bits); all other addresses read 0 and ignore writes.
REQ-014 in_port passes through SYNC_STAGES flops, then through the debounce filter, to form filt[WIDTH-1:0].
REQ-015 Debounce per bit: counter clears while sync bit equals filt bit; otherwise it increments; filt bit takes sync value on the cycle the counter reaches DEBOUNCE_CYCLES, and the counter clears.
REQ-016 With DEBOUNCE_CYCLES=0, filt equals the last synchronizer stage (no added latency).
REQ-017 in_port-to-filt latency: SYNC_STAGES cycles plus DEBOUNCE_CYCLES cycles.
REQ-018 prev register holds filt from the previous cycle; rise = filt & ~prev, fall = ~filt & prev.
REQ-019 edgesel: 0 level mode (no capture), 1 rising, 2 falling, 3 both edges.
REQ-020 edgecapture bit sets on a selected edge of its filt bit; bits never set while edgesel=0.
REQ-021 Write to address 3 clears each edgecapture bit whose writedata bit is 1; if a set and a clear hit the same bit in the same cycle, set wins.
REQ-022 Writing edgesel does not clear edgecapture; existing captured bits persist.
REQ-023 irq next value: edgesel=0 -> |(filt & irqmask); else -> |(edgecapture & irqmask); one cycle register latency.
REQ-024 readdata updates every cycle from address, independent of chipselect; value is visible one cycle after the address is presented.
REQ-025 Readdata bits above WIDTH (above 2 for edgesel) read 0; writedata bits above WIDTH ignored.
REQ-026 Write to irqmask/edgesel takes effect the following cycle; a same-cycle read returns the old value.

Reset
REQ-027 While reset=1: readdata=0, irq=0, irqmask=0, edgecapture=0, edgesel=0, prev=0, filt=0, synchronizers=0, debounce counters=0.
REQ-028 Reset asserted mid-debounce or with pending captures discards all state in one cycle; no edge is captured in the first cycle after reset even if in_port is high (edgesel=0).

Structure
REQ-029 Shared package nios2_c_pio_pkg holds register address constants (ADDR_DATA, ADDR_IRQMASK, ADDR_EDGECAP, ADDR_EDGESEL) and edgesel encodings (EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_ANY).
REQ-030 One sub-module nios2_c_pio_debounce (per-bit synchronizer + counter filter, parameters SYNC_STAGES, DEBOUNCE_CYCLES), instantiated WIDTH times via generate.
REQ-031 Counter width is the minimum bits to hold DEBOUNCE_CYCLES (at least 1).

Verification
REQ-032 Defaults, reset, in_port=4'b0101, irqmask=4'b0100, edgesel=0 -> read addr 0 = 0x5 after 2+1 cycles; irq=1 one cycle after filt/irqmask match.
REQ-033 edgesel=1, in_port bit1 0->1->0 -> edgecapture=0x2, stays 0x2 after fall; write 0x2 to addr 3 -> reads 0x0, irq drops next cycle.
REQ-034 edgesel=3, new rising edge on bit0 coinciding with a write of 0x1 to addr 3 -> edgecapture bit0 remains 1.
REQ-035 DEBOUNCE_CYCLES=8, bit2 glitch high for 5 cycles -> data bit2 stays 0, no capture; held high 8+ cycles -> data bit2=1 exactly SYNC_STAGES+8 cycles after the in_port change.
REQ-036 WIDTH=32, in_port=0xFFFF_FFFF, edgesel=2, assert reset for 1 cycle mid-operation -> all registers read 0; read addr 1, 5, 7 -> 0; irq=0.
